// File: rtl/timer_pkg.sv
// Shared encodings for the stopwatch/timer/clock control plane and datapath.
// Mode, edit-field and stopwatch sub-state enums.
package timer_pkg;

  typedef enum logic [1:0] {
    M_TIMER     = 2'd0,
    M_STOPWATCH = 2'd1,
    M_CLOCK     = 2'd2,
    M_ALARM     = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    F_NONE    = 2'd0,
    F_HOURS   = 2'd1,
    F_MINUTES = 2'd2,
    F_SECONDS = 2'd3
  } field_t;

  typedef enum logic [1:0] {
    SW_STOPPED  = 2'd0,
    SW_RUNNING  = 2'd1,
    SW_LAP_RUN  = 2'd2,
    SW_LAP_STOP = 2'd3
  } sw_state_t;

  function automatic mode_t next_mode(
    input mode_t m
  );
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/timer_mode_controller_if.sv
// Front-panel buttons, datapath status and control lines of the timer block.
// master: controller side; slave: panel/datapath side.
interface timer_mode_controller_if;
  logic       modeInput;
  logic       set;
  logic       startOrStop;
  logic       splitOrReset;
  logic       countdownZero;
  logic       alarmMatch;
  logic [1:0] mode;
  logic       loadCountdown;
  logic       countDownEnabled;
  logic       stopwatchRun;
  logic       lapCapture;
  logic       lapHold;
  logic       stopwatchClear;
  logic [1:0] editField;
  logic       editIncrement;
  logic       clockLoad;
  logic       alarmArmed;
  logic       ringSound;

  modport master (
    input  modeInput, set, startOrStop,
    input  splitOrReset,
    input  countdownZero, alarmMatch,
    output mode, loadCountdown,
    output countDownEnabled,
    output stopwatchRun, lapCapture,
    output lapHold, stopwatchClear,
    output editField, editIncrement,
    output clockLoad, alarmArmed,
    output ringSound
  );

  modport slave (
    output modeInput, set, startOrStop,
    output splitOrReset,
    output countdownZero, alarmMatch,
    input  mode, loadCountdown,
    input  countDownEnabled,
    input  stopwatchRun, lapCapture,
    input  lapHold, stopwatchClear,
    input  editField, editIncrement,
    input  clockLoad, alarmArmed,
    input  ringSound
  );
endinterface

// File: rtl/button_conditioner.sv
// Debounces one raw button and emits a 1-cycle press on each accepted 0->1.
// Ports: clockSignal, resetN (sync, low), raw in, press out.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clockSignal,
  input  logic resetN,
  input  logic raw,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ?
    $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          levelQ;
  logic [CW-1:0] cntQ;

  // cntQ counts consecutive samples that
  // disagree with the accepted level.
  always_ff @(posedge clockSignal) begin
    if (!resetN) begin
      levelQ <= 1'b0;
      cntQ   <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (raw == levelQ) begin
        cntQ <= '0;
      end else if (cntQ == LAST) begin
        levelQ <= raw;
        cntQ   <= '0;
        press  <= raw;
      end else begin
        cntQ <= cntQ + CW'(1);
      end
    end
  end

endmodule

// File: rtl/timer_mode_controller.sv
// Control-plane FSM: mode, per-mode sub-states, alarm arming, ring timer.
// Ports: clockSignal, resetN (sync, low), bus (timer_mode_controller_if.master).
module timer_mode_controller
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int RING_CYCLES     = 6000
) (
  input  logic clockSignal,
  input  logic resetN,
  timer_mode_controller_if.master bus
);

  localparam int RW = $clog2(RING_CYCLES + 1);
  localparam logic [RW-1:0] RING_LOAD =
    RW'(RING_CYCLES);

  logic evMode, evSet, evSs, evSr;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uMode (
    .clockSignal(clockSignal),
    .resetN     (resetN),
    .raw        (bus.modeInput),
    .press      (evMode)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uSet (
    .clockSignal(clockSignal),
    .resetN     (resetN),
    .raw        (bus.set),
    .press      (evSet)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uSs (
    .clockSignal(clockSignal),
    .resetN     (resetN),
    .raw        (bus.startOrStop),
    .press      (evSs)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uSr (
    .clockSignal(clockSignal),
    .resetN     (resetN),
    .raw        (bus.splitOrReset),
    .press      (evSr)
  );

  mode_t     modeQ, modeD;
  sw_state_t swQ, swD;
  field_t    fieldQ, fieldD;
  logic      cdeQ, cdeD;
  logic      armedQ, armedD;
  logic      ringQ, ringD;
  logic [RW-1:0] cntQ, cntD;
  logic      amQ;
  logic      loadQ, loadD;
  logic      lapcQ, lapcD;
  logic      clrQ, clrD;
  logic      incQ, incD;
  logic      cloadQ, cloadD;

  logic anyEv;
  logic eMode, eSet, eSs, eSr;
  logic cdTrig, alTrig;

  // Lower-priority events are masked so at
  // most one is acted on per cycle.
  assign anyEv = evMode | evSet | evSs | evSr;
  assign eMode = evMode;
  assign eSet  = evSet & ~evMode;
  assign eSs   = evSs & ~evMode & ~evSet;
  assign eSr   = evSr & ~evMode & ~evSet
               & ~evSs;
  assign cdTrig = bus.countdownZero & cdeQ;
  assign alTrig = bus.alarmMatch & ~amQ
                & armedQ;

  always_ff @(posedge clockSignal) begin
    if (!resetN) begin
      modeQ  <= M_TIMER;
      swQ    <= SW_STOPPED;
      fieldQ <= F_NONE;
      cdeQ   <= 1'b0;
      armedQ <= 1'b0;
      ringQ  <= 1'b0;
      cntQ   <= '0;
      amQ    <= 1'b0;
      loadQ  <= 1'b0;
      lapcQ  <= 1'b0;
      clrQ   <= 1'b0;
      incQ   <= 1'b0;
      cloadQ <= 1'b0;
    end else begin
      modeQ  <= modeD;
      swQ    <= swD;
      fieldQ <= fieldD;
      cdeQ   <= cdeD;
      armedQ <= armedD;
      ringQ  <= ringD;
      cntQ   <= cntD;
      amQ    <= bus.alarmMatch;
      loadQ  <= loadD;
      lapcQ  <= lapcD;
      clrQ   <= clrD;
      incQ   <= incD;
      cloadQ <= cloadD;
    end
  end

  always_comb begin
    modeD  = modeQ;
    swD    = swQ;
    fieldD = fieldQ;
    cdeD   = cdeQ;
    armedD = armedQ;
    ringD  = ringQ;
    cntD   = cntQ;
    loadD  = 1'b0;
    lapcD  = 1'b0;
    clrD   = 1'b0;
    incD   = 1'b0;
    cloadD = 1'b0;

    if (ringQ) begin
      if (cntQ <= RW'(1)) begin
        ringD = 1'b0;
        cntD  = '0;
      end else begin
        cntD = cntQ - RW'(1);
      end
    end

    // While ringing, a press only silences.
    if (ringQ && anyEv) begin
      ringD = 1'b0;
      cntD  = '0;
    end else begin
      unique case (1'b1)
        eMode: begin
          modeD = next_mode(modeQ);
          if (modeQ == M_CLOCK) begin
            fieldD = F_NONE;
          end
        end
        eSet: begin
          unique case (modeQ)
            M_TIMER: begin
              loadD = 1'b1;
              cdeD  = 1'b0;
            end
            M_CLOCK: begin
              fieldD = field_t'(fieldQ + 2'd1);
              cloadD = (fieldQ == F_SECONDS);
            end
            M_ALARM:     armedD = ~armedQ;
            M_STOPWATCH: ;
          endcase
        end
        eSs: begin
          unique case (modeQ)
            M_TIMER: cdeD = ~cdeQ;
            M_STOPWATCH: begin
              unique case (swQ)
                SW_STOPPED:  swD = SW_RUNNING;
                SW_RUNNING:  swD = SW_STOPPED;
                SW_LAP_RUN:  swD = SW_LAP_STOP;
                SW_LAP_STOP: swD = SW_LAP_RUN;
              endcase
            end
            M_CLOCK: incD = (fieldQ != F_NONE);
            M_ALARM: ;
          endcase
        end
        eSr: begin
          unique case (modeQ)
            M_TIMER: begin
              cdeD  = 1'b0;
              loadD = 1'b1;
            end
            M_STOPWATCH: begin
              unique case (swQ)
                SW_RUNNING: begin
                  swD   = SW_LAP_RUN;
                  lapcD = 1'b1;
                end
                SW_LAP_RUN:  swD  = SW_RUNNING;
                SW_LAP_STOP: swD  = SW_STOPPED;
                SW_STOPPED:  clrD = 1'b1;
              endcase
            end
            M_CLOCK: fieldD = F_NONE;
            M_ALARM: ;
          endcase
        end
        default: ;
      endcase
    end

    // A fresh trigger (re)starts the ring.
    if (cdTrig || alTrig) begin
      ringD = 1'b1;
      cntD  = RING_LOAD;
    end
    if (cdTrig) begin
      cdeD = 1'b0;
    end

    // Keep every strobe single-cycle.
    loadD  = loadD & ~loadQ;
    lapcD  = lapcD & ~lapcQ;
    clrD   = clrD & ~clrQ;
    incD   = incD & ~incQ;
    cloadD = cloadD & ~cloadQ;
  end

  assign bus.mode             = modeQ;
  assign bus.loadCountdown    = loadQ;
  assign bus.countDownEnabled = cdeQ;
  assign bus.stopwatchRun     =
    (swQ == SW_RUNNING) ||
    (swQ == SW_LAP_RUN);
  assign bus.lapCapture       = lapcQ;
  assign bus.lapHold          =
    (swQ == SW_LAP_RUN) ||
    (swQ == SW_LAP_STOP);
  assign bus.stopwatchClear   = clrQ;
  assign bus.editField        = fieldQ;
  assign bus.editIncrement    = incQ;
  assign bus.clockLoad        = cloadQ;
  assign bus.alarmArmed       = armedQ;
  assign bus.ringSound        = ringQ;

endmodule

// File: tb/tb_timer_mode_controller.sv
// Directed self-checking bench for timer_mode_controller.
// Buttons are held 3 cycles; strobes are tallied on negedge.
module tb_timer_mode_controller;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic [3:0] btn = 4'b0;
  logic cz = 1'b0;
  logic am = 1'b0;
  int tests = 0;
  int fails = 0;

  int nLoad = 0, nLapc = 0, nClr = 0;
  int nInc = 0, nCload = 0;

  localparam int B_MODE = 0;
  localparam int B_SET  = 1;
  localparam int B_SS   = 2;
  localparam int B_SR   = 3;

  always #5 clk = ~clk;

  timer_mode_controller_if bus ();

  assign bus.modeInput     = btn[B_MODE];
  assign bus.set           = btn[B_SET];
  assign bus.startOrStop   = btn[B_SS];
  assign bus.splitOrReset  = btn[B_SR];
  assign bus.countdownZero = cz;
  assign bus.alarmMatch    = am;

  timer_mode_controller #(
    .DEBOUNCE_CYCLES(2),
    .RING_CYCLES    (6000)
  ) dut (
    .clockSignal(clk),
    .resetN     (resetN),
    .bus        (bus)
  );

  always @(negedge clk) begin
    if (bus.loadCountdown)  nLoad++;
    if (bus.lapCapture)     nLapc++;
    if (bus.stopwatchClear) nClr++;
    if (bus.editIncrement)  nInc++;
    if (bus.clockLoad)      nCload++;
  end

  function automatic logic [14:0] outs();
    return {bus.mode, bus.loadCountdown,
      bus.countDownEnabled,
      bus.stopwatchRun, bus.lapCapture,
      bus.lapHold, bus.stopwatchClear,
      bus.editField, bus.editIncrement,
      bus.clockLoad, bus.alarmArmed,
      bus.ringSound};
  endfunction

  task automatic press(input int b,
                       input int hold);
    btn[b] = 1'b1;
    repeat (hold) @(negedge clk);
    btn[b] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (outs() !== 15'h0) begin
      fails++;
      $display("FAIL reset_init got %h want 0",
        outs());
    end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    press(B_SS, 3);
    press(B_MODE, 3);
    press(B_SS, 3);
    press(B_MODE, 3);
    cz = 1'b1;
    @(negedge clk);
    cz = 1'b0;
    tests++;
    if ({bus.stopwatchRun, bus.mode,
         bus.ringSound,
         bus.countDownEnabled}
        !== 5'b1_10_1_0) begin
      fails++;
      $display("FAIL mid_setup got %b%b%b%b",
        bus.stopwatchRun, bus.mode,
        bus.ringSound, bus.countDownEnabled);
    end
    repeat (3) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    tests++;
    if (outs() !== 15'h0) begin
      fails++;
      $display("FAIL reset_mid got %h want 0",
        outs());
    end
    @(negedge clk);
  endtask

  task automatic test_mode();
    for (int i = 1; i <= 3; i++) begin
      press(B_MODE, 3);
      tests++;
      if (bus.mode !== 2'(i)) begin
        fails++;
        $display("FAIL mode_step%0d got %0d want %0d",
          i, bus.mode, i);
      end
    end
    press(B_MODE, 10);
    tests++;
    if (bus.mode !== 2'd0) begin
      fails++;
      $display("FAIL mode_hold got %0d want 0",
        bus.mode);
    end
  endtask

  task automatic test_debounce();
    int l0;
    l0 = nLoad;
    btn[B_SET] = 1'b1;
    @(negedge clk);
    btn[B_SET] = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (nLoad - l0 !== 0) begin
      fails++;
      $display("FAIL glitch loads got %0d want 0",
        nLoad - l0);
    end
    press(B_SET, 3);
    tests++;
    if (nLoad - l0 !== 1 ||
        bus.countDownEnabled !== 1'b0) begin
      fails++;
      $display("FAIL set_load got %0d/%b want 1/0",
        nLoad - l0, bus.countDownEnabled);
    end
  endtask

  task automatic test_stopwatch();
    int c0, k0;
    c0 = nLapc;
    k0 = nClr;
    press(B_MODE, 3);
    press(B_SS, 3);
    tests++;
    if (bus.stopwatchRun !== 1'b1) begin
      fails++;
      $display("FAIL sw_start got %b want 1",
        bus.stopwatchRun);
    end
    press(B_SR, 3);
    tests++;
    if (nLapc - c0 !== 1 ||
        bus.lapHold !== 1'b1) begin
      fails++;
      $display("FAIL sw_split1 got %0d/%b want 1/1",
        nLapc - c0, bus.lapHold);
    end
    press(B_SR, 3);
    tests++;
    if (nLapc - c0 !== 1 ||
        bus.lapHold !== 1'b0 ||
        bus.stopwatchRun !== 1'b1) begin
      fails++;
      $display("FAIL sw_split2 got %0d/%b/%b want 1/0/1",
        nLapc - c0, bus.lapHold,
        bus.stopwatchRun);
    end
    press(B_SS, 3);
    tests++;
    if (bus.stopwatchRun !== 1'b0) begin
      fails++;
      $display("FAIL sw_stop got %b want 0",
        bus.stopwatchRun);
    end
    press(B_SR, 3);
    tests++;
    if (nClr - k0 !== 1 ||
        bus.lapHold !== 1'b0) begin
      fails++;
      $display("FAIL sw_clear got %0d/%b want 1/0",
        nClr - k0, bus.lapHold);
    end
  endtask

  task automatic test_clock();
    int i0, l0;
    logic [1:0] exp;
    press(B_MODE, 3);
    i0 = nInc;
    l0 = nCload;
    press(B_SS, 3);
    tests++;
    if (nInc - i0 !== 0) begin
      fails++;
      $display("FAIL clk_idle_inc got %0d want 0",
        nInc - i0);
    end
    for (int s = 1; s <= 4; s++) begin
      press(B_SET, 3);
      exp = 2'(s % 4);
      tests++;
      if (bus.editField !== exp) begin
        fails++;
        $display("FAIL clk_field%0d got %0d want %0d",
          s, bus.editField, exp);
      end
      if (s < 4) press(B_SS, 3);
    end
    tests++;
    if (nInc - i0 !== 3 ||
        nCload - l0 !== 1) begin
      fails++;
      $display("FAIL clk_strobes got %0d/%0d want 3/1",
        nInc - i0, nCload - l0);
    end
  endtask

  task automatic test_ring();
    int n, l0;
    logic [14:0] snap;
    press(B_MODE, 3);
    press(B_MODE, 3);
    press(B_SS, 3);
    cz = 1'b1;
    @(negedge clk);
    cz = 1'b0;
    tests++;
    if (bus.ringSound !== 1'b1 ||
        bus.countDownEnabled !== 1'b0) begin
      fails++;
      $display("FAIL ring_start got %b/%b want 1/0",
        bus.ringSound, bus.countDownEnabled);
    end
    n = 1;
    for (int k = 0; k < 7000; k++) begin
      @(negedge clk);
      if (!bus.ringSound) break;
      n++;
    end
    tests++;
    if (n !== 6000) begin
      fails++;
      $display("FAIL ring_len got %0d want 6000",
        n);
    end
    press(B_SS, 3);
    cz = 1'b1;
    @(negedge clk);
    cz = 1'b0;
    repeat (5) @(negedge clk);
    l0 = nLoad;
    snap = outs();
    btn[B_SET] = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.ringSound !== 1'b1) begin
      fails++;
      $display("FAIL ring_early got %b want 1",
        bus.ringSound);
    end
    @(negedge clk);
    btn[B_SET] = 1'b0;
    tests++;
    if (outs() !== {snap[14:1], 1'b0}) begin
      fails++;
      $display("FAIL ring_silence got %h want %h",
        outs(), {snap[14:1], 1'b0});
    end
    repeat (4) @(negedge clk);
    tests++;
    if (nLoad - l0 !== 0 ||
        bus.mode !== 2'd0) begin
      fails++;
      $display("FAIL ring_consume got %0d/%0d want 0/0",
        nLoad - l0, bus.mode);
    end
  endtask

  task automatic test_alarm();
    repeat (3) press(B_MODE, 3);
    press(B_SET, 3);
    tests++;
    if (bus.mode !== 2'd3 ||
        bus.alarmArmed !== 1'b1) begin
      fails++;
      $display("FAIL alarm_arm got %0d/%b want 3/1",
        bus.mode, bus.alarmArmed);
    end
    am = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.ringSound !== 1'b1) begin
      fails++;
      $display("FAIL alarm_ring got %b want 1",
        bus.ringSound);
    end
    press(B_SS, 3);
    repeat (3) @(negedge clk);
    tests++;
    if (bus.ringSound !== 1'b0 ||
        bus.alarmArmed !== 1'b1) begin
      fails++;
      $display("FAIL alarm_quiet got %b/%b want 0/1",
        bus.ringSound, bus.alarmArmed);
    end
    am = 1'b0;
    press(B_SET, 3);
    tests++;
    if (bus.alarmArmed !== 1'b0) begin
      fails++;
      $display("FAIL alarm_disarm got %b want 0",
        bus.alarmArmed);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_mode();
    test_debounce();
    test_stopwatch();
    test_clock();
    test_ring();
    test_alarm();
    $display("[TB] %0d tests run, %0d failed",
      tests, fails);
    $finish;
  end

endmodule
